rr_arbiter32: RTL
=================

# rr_arbiter32

Round-robin arbiter that shares one resource among 32 requesters, e.g. a display, UART or 7-segment driver on the Basys3 top level. It issues one grant at a time, one-hot and encoded, holds it until the owner releases it or a hold timeout expires, then rotates priority past the last owner. The one-hot to 5-bit conversion uses the same lowest-index priority-encode function as the team's 32-to-5 encoder, applied to a rotated request vector.

## Interface
- N, 32: number of requesters; fixed at 32 in this revision.
- IDW, 5: grant index width, equal to clog2(N).
- MAX_HOLD, 16: maximum cycles a grant may be held; legal range 2..256.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit i means requester i wants the resource.
- mask  in  N  bit i = 1 excludes requester i from new arbitration.
- release  in  1  the current owner gives up the grant; ignored unless in BUSY.
- gnt  out  N  one-hot grant; all zero when idle.
- gnt_id  out  IDW  index of the granted requester; 0 when gnt_valid = 0.
- gnt_valid  out  1  a grant is active; equals |gnt.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- Eligible vector: elig = req & ~mask.
- Pointer ptr (IDW bits) is the highest-priority index. Search order is ptr, ptr+1, …, 31, 0, …, ptr−1.
- Implementation of the search: rotate elig right by ptr, take the lowest set bit (pri_enc32), then winner = (idx + ptr) mod 32. All arithmetic is 5-bit, so wrap is natural.
- FSM states: IDLE, BUSY, GAP.
  - IDLE: if elig ≠ 0, latch winner into gnt/gnt_id and go to BUSY. Otherwise stay.
  - BUSY: hold_cnt increments each cycle. Exit to GAP when any of these holds:
    - release = 1;
    - req[gnt_id] = 0 (the requester dropped out);
    - hold_cnt = MAX_HOLD−1 (timeout).
    - On exit: ptr ← gnt_id+1 mod 32, gnt ← 0, hold_cnt ← 0.
  - GAP: one dead cycle with gnt = 0. timeout = 1 in this cycle only if the exit was a timeout. At the end of GAP, arbitrate exactly as in IDLE: go to BUSY if elig ≠ 0, else go to IDLE.
- Priority when exit conditions coincide: release or a dropped request takes priority over timeout. timeout pulses only when hold_cnt reached its limit with release = 0 and req[gnt_id] = 1.
- mask changes never revoke an active grant; they affect only the next arbitration.
- No grant is ever issued to a requester whose elig bit was 0 at the arbitration edge.

## Timing
- Reset: gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, ptr = 0, hold_cnt = 0, state = IDLE.
- rst has priority over every other input. If rst is asserted mid-grant, all outputs are 0 after that edge.
- Request to grant: elig sampled at edge k (IDLE) gives gnt valid from edge k onward, so it is visible in cycle k+1. All outputs are registered.
- Release to next grant: release sampled at edge k clears gnt at edge k. GAP occupies cycle k+1, and the next grant is visible from edge k+1. There is exactly one dead cycle.
- Maximum hold: the grant stays asserted for exactly MAX_HOLD cycles.
- Worst-case wait for a continuously requesting, unmasked requester: 31·(MAX_HOLD+1) cycles.

## Structure
- Package arb_pkg holds:
  - N and IDW constants;
  - the state encoding localparams IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2;
  - the MAX_HOLD default.
- Sub-module pri_enc32 is combinational. Input D[31:0]; outputs Y[4:0] (lowest set index) and V. It is instantiated once.
- Everything else (rotator, FSM, ptr, hold_cnt) lives in rr_arbiter32.

## Test plan
- Reset: hold rst 3 cycles with req = 32'hFFFF_FFFF → gnt = 0, gnt_valid = 0, timeout = 0 throughout. After release of rst, the first grant is gnt_id = 0.
- Single request: req = 32'h0000_0020. Expect gnt = 32'h20, gnt_id = 5 one cycle later. Pulse release → gnt = 0 next cycle (GAP), then re-grant to 5 after the GAP.
- Rotation: req bits 3, 7 and 20 held; release every grant after 2 cycles → grant order 3, 7, 20, 3, with exactly one zero-grant cycle between grants.
- Wrap-around: force ptr to 31 via a grant to 31, with req = bits {31, 0, 1} → after 31 the order is 0, then 1.
- Timeout: MAX_HOLD = 16, req bits 9 and 10 held, no release → grant 9 for exactly 16 cycles, timeout = 1 in the GAP cycle, then grant 10.
- Mask and reset: with req = 32'hF and mask = 32'h2, grant 0 then release → next grant is 2, skipping 1. Assert rst during that grant → all outputs 0 next cycle, ptr back to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and small vector helpers for the 32-way
// round-robin arbiter.
package arb_pkg;

   localparam int N            = 32;
   localparam int IDW          = 5;
   localparam int MAX_HOLD_DEF = 16;
   localparam int HCW          = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUSY = BUSY,
      ST_GAP  = GAP
   } state_t;

   // Rotate right by sh positions; the doubled vector makes the wrap implicit.
   function automatic logic [N-1:0] rot_right(input logic [N-1:0] vec,
                                              input logic [IDW-1:0] sh);
      logic [2*N-1:0] dbl;
      dbl = {vec, vec} >> sh;
      return dbl[N-1:0];
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
      return {{(N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter32_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// The owner-release strobe is gnt_release because "release" is a reserved word.
interface rr_arbiter32_if;
   import arb_pkg::*;

   logic [N-1:0]   req;
   logic [N-1:0]   mask;
   logic           gnt_release;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   modport master (
      output req, mask, gnt_release,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req, mask, gnt_release,
      output gnt, gnt_id, gnt_valid, timeout
   );

endinterface

// File: rtl/rr_arbiter32_pri_enc32.sv
// 32-to-5 priority encoder: Y is the lowest set index of D, V flags any bit set.
module pri_enc32
   import arb_pkg::*;
(
   input  logic [N-1:0]   D,
   output logic [IDW-1:0] Y,
   output logic           V
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      Y = {IDW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         Y = D[i] ? IDW'(i) : Y;
      end
   end

   assign V = |D;

endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters with hold timeout and one dead cycle
// between consecutive grants.
module rr_arbiter32
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   rr_arbiter32_if.slave bus
);

   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   state_t         state_r;
   state_t         state_nxt_s;
   logic [N-1:0]   gnt_r;
   logic [N-1:0]   gnt_nxt_s;
   logic [IDW-1:0] gnt_id_r;
   logic [IDW-1:0] gnt_id_nxt_s;
   logic           gnt_valid_r;
   logic           timeout_r;
   logic           timeout_nxt_s;
   logic [IDW-1:0] ptr_r;
   logic [IDW-1:0] ptr_nxt_s;
   logic [HCW-1:0] hold_cnt_r;
   logic [HCW-1:0] hold_cnt_nxt_s;

   logic [N-1:0]   elig_s;
   logic [N-1:0]   rot_s;
   logic [IDW-1:0] enc_idx_s;
   logic           enc_v_s;
   logic [IDW-1:0] win_s;
   logic           owner_drop_s;

   // Search starts at ptr: rotate it down to bit 0, encode, then undo the rotation.
   assign elig_s       = bus.req & ~bus.mask;
   assign rot_s        = rot_right(elig_s, ptr_r);
   assign win_s        = enc_idx_s + ptr_r;
   assign owner_drop_s = bus.gnt_release | ~bus.req[gnt_id_r];

   pri_enc32 u_enc (
      .D (rot_s),
      .Y (enc_idx_s),
      .V (enc_v_s)
   );

   // Next-state and next-output logic for the IDLE/BUSY/GAP sequence.
   always_comb begin
      state_nxt_s    = state_r;
      gnt_nxt_s      = gnt_r;
      gnt_id_nxt_s   = gnt_id_r;
      ptr_nxt_s      = ptr_r;
      hold_cnt_nxt_s = hold_cnt_r;
      timeout_nxt_s  = 1'b0;

      case (state_r)
         ST_IDLE, ST_GAP: begin
            if (enc_v_s) begin
               state_nxt_s    = ST_BUSY;
               gnt_nxt_s      = onehot(win_s);
               gnt_id_nxt_s   = win_s;
               hold_cnt_nxt_s = {HCW{1'b0}};
            end else begin
               state_nxt_s    = ST_IDLE;
               gnt_nxt_s      = {N{1'b0}};
               gnt_id_nxt_s   = {IDW{1'b0}};
               hold_cnt_nxt_s = {HCW{1'b0}};
            end
         end

         ST_BUSY: begin
            // A voluntary exit outranks the timeout, so no pulse in that case.
            if (owner_drop_s || (hold_cnt_r == HOLD_LAST)) begin
               state_nxt_s    = ST_GAP;
               gnt_nxt_s      = {N{1'b0}};
               gnt_id_nxt_s   = {IDW{1'b0}};
               ptr_nxt_s      = gnt_id_r + {{(IDW-1){1'b0}}, 1'b1};
               hold_cnt_nxt_s = {HCW{1'b0}};
               timeout_nxt_s  = ~owner_drop_s;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r + {{(HCW-1){1'b0}}, 1'b1};
            end
         end

         default: begin
            state_nxt_s    = ST_IDLE;
            gnt_nxt_s      = {N{1'b0}};
            gnt_id_nxt_s   = {IDW{1'b0}};
            ptr_nxt_s      = {IDW{1'b0}};
            hold_cnt_nxt_s = {HCW{1'b0}};
         end
      endcase
   end

   // State and output registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         gnt_r       <= {N{1'b0}};
         gnt_id_r    <= {IDW{1'b0}};
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
         ptr_r       <= {IDW{1'b0}};
         hold_cnt_r  <= {HCW{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         gnt_r       <= gnt_nxt_s;
         gnt_id_r    <= gnt_id_nxt_s;
         gnt_valid_r <= |gnt_nxt_s;
         timeout_r   <= timeout_nxt_s;
         ptr_r       <= ptr_nxt_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_id    = gnt_id_r;
   assign bus.gnt_valid = gnt_valid_r;
   assign bus.timeout   = timeout_r;

endmodule
